// File: rtl/elevador_pkg.sv
// Shared types and default parameters for the elevator call scheduler.
// The HALT state is used only when CALL_SCHED_ESTOP_EN is defined.
package elevador_pkg;
  localparam int FLOORS_DEF        = 8;
  localparam int FLOOR_W_DEF       = 3;
  localparam int DOOR_CYCLES_DEF   = 4;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int TMR_W             = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    SETTLE = 3'd2,
    DOOR   = 3'd3,
    HALT   = 3'd4
  } state_t;
endpackage

// File: rtl/elevator_call_scheduler_call_register.sv
// Latched floor calls, plus the above/below/here reductions that the SCAN
// decision uses. Set wins over clear, so a held button re-registers at once.
module call_register
  import elevador_pkg::*;
#(
  parameter int FLOORS  = FLOORS_DEF,
  parameter int FLOOR_W = FLOOR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  i_call_n,
  input  logic [FLOOR_W-1:0] i_cur_floor,
  input  logic               i_clr,
  output logic [FLOORS-1:0]  o_pending,
  output logic               o_ahead_up,
  output logic               o_ahead_dn,
  output logic               o_here
);
  logic [FLOORS-1:0] r_pending;
  logic [FLOORS-1:0] w_clr_mask;
  logic              w_ahead_up;
  logic              w_ahead_dn;
  logic              w_here;

  // An out-of-range floor matches no bit, so it is never "here"
  always_comb begin
    w_clr_mask = '0;
    w_ahead_up = 1'b0;
    w_ahead_dn = 1'b0;
    w_here     = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      w_clr_mask[i] = i_clr && (i == int'(i_cur_floor));
      if (r_pending[i]) begin
        if (i > int'(i_cur_floor))  w_ahead_up = 1'b1;
        if (i < int'(i_cur_floor))  w_ahead_dn = 1'b1;
        if (i == int'(i_cur_floor)) w_here     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr_mask) | ~i_call_n;
  end

  assign o_pending  = r_pending;
  assign o_ahead_up = w_ahead_up;
  assign o_ahead_dn = w_ahead_dn;
  assign o_here     = w_here;
endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) scheduler driving the floor counter's step and hold inputs.
// Define CALL_SCHED_ESTOP_EN to add the estop_n input and the HALT state.
//
// state  | meaning
// IDLE   | evaluate calls: serve here, continue, reverse or wait
// STEP   | one-cycle active-low step pulse toward the target
// SETTLE | let the counter settle, then re-evaluate
// DOOR   | door open, counter held, dwell timer running
// HALT   | emergency stop: counter held, no pulses (estop build only)
module elevator_call_scheduler
  import elevador_pkg::*;
#(
  parameter int FLOORS        = FLOORS_DEF,
  parameter int FLOOR_W       = FLOOR_W_DEF,
  parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call_n,
  input  logic [FLOOR_W-1:0] cur_floor,
`ifdef CALL_SCHED_ESTOP_EN
  input  logic               estop_n,
`endif
  output logic               up_n,
  output logic               down_n,
  output logic               hold,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic               dir_up
);
  localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  state_t             r_state, w_state_nxt, w_dec_state;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic               r_dir_up, w_dir_nxt, w_dec_dir;
  logic               w_ahead_up, w_ahead_dn, w_here;
  logic               w_clr, w_call_here, w_estop;
  logic               w_at_top, w_at_bot;

`ifdef CALL_SCHED_ESTOP_EN
  assign w_estop = !estop_n;
`else
  assign w_estop = 1'b0;
`endif

  call_register #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_calls (
    .clk        (clk),
    .reset      (reset),
    .i_call_n   (call_n),
    .i_cur_floor(cur_floor),
    .i_clr      (w_clr),
    .o_pending  (pending),
    .o_ahead_up (w_ahead_up),
    .o_ahead_dn (w_ahead_dn),
    .o_here     (w_here)
  );

  always_comb begin
    w_call_here = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i == int'(cur_floor) && !call_n[i]) w_call_here = 1'b1;
  end

  assign w_at_top = (cur_floor == FLOOR_W'(FLOORS - 1));
  assign w_at_bot = (cur_floor == '0);

  // Shared IDLE / end-of-SETTLE decision
  always_comb begin
    w_dec_state = IDLE;
    w_dec_dir   = r_dir_up;
    if (w_here) begin
      w_dec_state = DOOR;
    end else if (r_dir_up ? w_ahead_up : w_ahead_dn) begin
      w_dec_state = STEP;
    end else if (w_ahead_up || w_ahead_dn) begin
      w_dec_state = STEP;
      w_dec_dir   = ~r_dir_up;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir_up;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_dec_state;
        w_dir_nxt   = w_dec_dir;
      end
      STEP: begin
        w_state_nxt = SETTLE;
        w_timer_nxt = SETTLE_LOAD;
      end
      SETTLE: begin
        if (r_timer == '0) begin
          w_state_nxt = w_dec_state;
          w_dir_nxt   = w_dec_dir;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      DOOR: begin
        if (w_call_here)          w_timer_nxt = DOOR_LOAD;
        else if (r_timer == '0)   w_state_nxt = IDLE;
        else                      w_timer_nxt = r_timer - TMR_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == DOOR && r_state != DOOR) w_timer_nxt = DOOR_LOAD;
    if (w_estop) begin
      w_state_nxt = HALT;
      w_dir_nxt   = r_dir_up;
    end
  end

  // Clearing on every DOOR cycle covers both entry and re-presses while open
  assign w_clr = (w_state_nxt == DOOR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_dir_up <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_dir_up <= w_dir_nxt;
    end
  end

  assign up_n      = !(r_state == STEP &&  r_dir_up && !w_at_top && !w_estop);
  assign down_n    = !(r_state == STEP && !r_dir_up && !w_at_bot && !w_estop);
  assign door_open = (r_state == DOOR);
  assign hold      = (r_state == DOOR) || (r_state == HALT);
  assign dir_up    = r_dir_up;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Closed-loop bench: the scheduler drives a behavioural up/down floor counter;
// a SCAN reference model predicts each stop and a monitor checks door events.
module tb_elevator_call_scheduler;
  localparam int FL     = 8;
  localparam int DOOR   = 4;
  localparam int SETTLE = 2;

  typedef struct {
    int floor;
    int dir;
    int pulses;
    int width;
  } stop_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [FL-1:0] call_n = '1;
  logic [2:0]    cnt = 3'd0;
  logic          up_n, down_n, hold, door_open, dir_up;
  logic [FL-1:0] pending;
`ifdef CALL_SCHED_ESTOP_EN
  logic          estop_n = 1'b1;
`endif

  int    errors = 0;
  int    checks = 0;
  stop_t sb_q[$];
  bit    halt_flag = 1'b0;
  int    m_floor = 0;
  int    m_dir = 1;

  always #5 clk = ~clk;

  elevator_call_scheduler #(.FLOORS(FL), .FLOOR_W(3), .DOOR_CYCLES(DOOR),
                            .SETTLE_CYCLES(SETTLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .call_n   (call_n),
    .cur_floor(cnt),
`ifdef CALL_SCHED_ESTOP_EN
    .estop_n  (estop_n),
`endif
    .up_n     (up_n),
    .down_n   (down_n),
    .hold     (hold),
    .door_open(door_open),
    .pending  (pending),
    .dir_up   (dir_up)
  );

  // The existing floor counter: active-low steps, frozen while hold is high
  always @(posedge clk) begin
    if (!hold) begin
      if (!up_n && cnt != 3'd7)      cnt <= cnt + 3'd1;
      else if (!down_n && cnt != 3'd0) cnt <= cnt - 3'd1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: SCAN order from the current floor and direction
  task automatic push_stops(input logic [FL-1:0] m);
    int prev;
    prev = m_floor;
    if (m[m_floor]) sb_q.push_back('{m_floor, m_dir, 0, DOOR});
    if (m_dir == 1) begin
      for (int i = m_floor + 1; i < FL; i++)
        if (m[i]) begin sb_q.push_back('{i, 1, i - prev, DOOR}); prev = i; end
      for (int i = m_floor - 1; i >= 0; i--)
        if (m[i]) begin sb_q.push_back('{i, 0, prev - i, DOOR}); prev = i; m_dir = 0; end
    end else begin
      for (int i = m_floor - 1; i >= 0; i--)
        if (m[i]) begin sb_q.push_back('{i, 0, prev - i, DOOR}); prev = i; end
      for (int i = m_floor + 1; i < FL; i++)
        if (m[i]) begin sb_q.push_back('{i, 1, i - prev, DOOR}); prev = i; m_dir = 1; end
    end
    m_floor = prev;
  endtask

  // Monitor: pops a predicted stop at each door opening
  int    cyc = 0, leg_pulses = 0, last_pulse = -1, door_w = 0;
  bit    prev_door = 1'b0;
  stop_t cur_stop = '{0, 0, 0, DOOR};
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      leg_pulses = 0; last_pulse = -1; door_w = 0; prev_door = 1'b0;
    end else begin
      check("both_pulses", int'(!up_n && !down_n), 0);
      check("pulse_in_hold", int'(hold && (!up_n || !down_n)), 0);
      check("up_at_top", int'(!up_n && cnt == 3'd7), 0);
      check("down_at_bottom", int'(!down_n && cnt == 3'd0), 0);
      if (!halt_flag) check("hold_eq_door", int'(hold), int'(door_open));
      else last_pulse = -1;
      if (!up_n || !down_n) begin
        if (last_pulse >= 0) check("pulse_gap", cyc - last_pulse, SETTLE + 1);
        last_pulse = cyc;
        leg_pulses++;
      end
      if (door_open && !prev_door) begin
        if (sb_q.size() == 0) begin
          check("unexpected_stop_floor", int'(cnt), -1);
          cur_stop = '{0, 0, 0, DOOR};
        end else begin
          cur_stop = sb_q.pop_front();
          check("stop_floor", int'(cnt), cur_stop.floor);
          check("stop_dir", int'(dir_up), cur_stop.dir);
          check("leg_pulses", leg_pulses, cur_stop.pulses);
          check("pending_cleared", int'(pending[cnt]), 0);
        end
        leg_pulses = 0; last_pulse = -1; door_w = 0;
      end
      if (door_open) door_w++;
      if (!door_open && prev_door) check("door_width", door_w, cur_stop.width);
      prev_door = door_open;
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((pending != '0 || door_open) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check({tag, "_idle_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
    check({tag, "_final_floor"}, int'(cnt), m_floor);
    check({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  // Issue a one-cycle call pattern from idle; optionally re-press during the dwell
  task automatic run_batch(input logic [FL-1:0] m, input bit restart);
    int lat, n;
    push_stops(m);
    if (restart) sb_q[sb_q.size()-1].width = DOOR + 3;
    @(negedge clk);
    call_n = ~m;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk); call_n = '1;
    end while (up_n && down_n && !door_open && lat < 10);
    check("first_event_latency", lat, 2);
    if (restart) begin
      n = 0;
      while (!door_open && n < 300) begin @(negedge clk); n++; end
      check("restart_door_seen", int'(door_open), 1);
      repeat (2) @(negedge clk);
      call_n[m_floor] = 1'b0;
      @(negedge clk);
      call_n = '1;
      check("restart_door_held", int'(door_open), 1);
    end
    wait_idle("batch");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_up_n"}, int'(up_n), 1);
    check({tag, "_down_n"}, int'(down_n), 1);
    check({tag, "_hold"}, int'(hold), 0);
    check({tag, "_door_open"}, int'(door_open), 0);
    check({tag, "_pending"}, int'(pending), 0);
    check({tag, "_dir_up"}, int'(dir_up), 1);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FL-1:0] m;
    int n, pulses, tgt;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    run_batch(8'b0000_1000, 1'b0);   // 0 -> 3
    run_batch(8'b0000_0001, 1'b0);   // back to 0, direction now down
    run_batch(8'b0010_0100, 1'b0);   // reverse, stop at 2 then 5
    run_batch(8'b1000_0010, 1'b0);   // 7 first, then reverse to 1
    run_batch(8'b0001_0000, 1'b1);   // door re-press at 4
    for (int k = 0; k < 20; k++) begin
      m = FL'($urandom & $urandom);
      if (m == '0) m[$urandom_range(0, FL - 1)] = 1'b1;
      run_batch(m, 1'b0);
    end

    // Reset during SETTLE while travelling
    tgt = (m_floor < 4) ? 7 : 0;
    @(negedge clk);
    call_n[tgt] = 1'b0;
    @(negedge clk);
    call_n = '1;
    n = 0;
    while (up_n && down_n && n < 20) begin @(negedge clk); n++; end
    check("pre_reset_pulse_seen", int'(!up_n || !down_n), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_floor = int'(cnt);
    m_dir = 1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (!up_n || !down_n) pulses++;
    end
    check("post_reset_pulses", pulses, 0);
    check("post_reset_pending", int'(pending), 0);

`ifdef CALL_SCHED_ESTOP_EN
    // Emergency stop mid-travel, then resume to the same target
    tgt = (m_floor < 4) ? 7 : 0;
    m = '0;
    m[tgt] = 1'b1;
    push_stops(m);
    @(negedge clk);
    call_n = ~m;
    @(negedge clk);
    call_n = '1;
    n = 0;
    while (up_n && down_n && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    estop_n = 1'b0;
    halt_flag = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("estop_hold", int'(hold), 1);
      check("estop_no_pulse", int'(up_n && down_n), 1);
      check("estop_door", int'(door_open), 0);
      check("estop_pending", int'(pending), int'(m));
    end
    estop_n = 1'b1;
    @(negedge clk);
    halt_flag = 1'b0;
    wait_idle("estop");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Upstream control stage for the floor up/down counter. Latches floor-call buttons, runs a collective (SCAN) scheduler, and drives the counter's active-low up/down step inputs and its hold/pause input.
Takes the counter's current floor as feedback. Opens the door at served floors and holds the car for a fixed dwell.

Parameters:
FLOORS, 8, number of floors (counter range 0..FLOORS-1)
FLOOR_W, 3, floor index width, clog2(FLOORS)
DOOR_CYCLES, 4, clock cycles the door stays open per stop
SETTLE_CYCLES, 2, cycles waited after each step pulse before re-evaluating (must be >=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
call_n  in  FLOORS  floor call buttons, active-low, level; bit i = floor i
cur_floor  in  FLOOR_W  current floor from the up/down counter
up_n  out  1  step-up command to counter, active-low, one-cycle pulse
down_n  out  1  step-down command to counter, active-low, one-cycle pulse
hold  out  1  counter hold/pause (P); high freezes the counter
door_open  out  1  door open indicator
pending  out  FLOORS  registered outstanding calls
dir_up  out  1  current/last travel direction, 1 = up

Behaviour:
- Clock is clk; reset is asynchronous, active-low. On reset: up_n=1, down_n=1, hold=0, door_open=0, pending=0, dir_up=1. State=IDLE, timers=0.
- Call register: pending[i] is set in any cycle call_n[i]=0. It clears only on the cycle DOOR is entered at floor i. Set wins over clear in the same cycle, so a held button re-registers.
- Aggregates: ahead_up = any pending above cur_floor; ahead_dn = any pending below cur_floor; here = pending[cur_floor].
- States: IDLE, STEP, SETTLE, DOOR.
- IDLE:
  - here -> DOOR.
  - Otherwise, if dir_up and ahead_up -> STEP up.
  - Otherwise, if !dir_up and ahead_dn -> STEP down.
  - Otherwise the direction reverses if the opposite side has calls (dir_up toggles) -> STEP.
  - Otherwise stay in IDLE.
- STEP (1 cycle): assert up_n=0 if dir_up, else down_n=0. Never both. Go to SETTLE, timer=SETTLE_CYCLES-1.
- SETTLE: hold=0, no pulses. Count down. At 0, use the same decision as IDLE (here -> DOOR; same direction ahead -> STEP; reverse; none -> IDLE).
- DOOR:
  - On entry: door_open=1, hold=1, pending[cur_floor] cleared, timer=DOOR_CYCLES-1.
  - A new call at cur_floor while in DOOR clears again and restarts the timer.
  - At timer 0: door_open=0, hold=0; go to IDLE next cycle.
- Boundaries: no up pulse when cur_floor==FLOORS-1; no down pulse when cur_floor==0. Ahead logic guarantees this, and an explicit guard is also required.
- Out-of-range cur_floor (>=FLOORS) is treated as no-call-here.
- Latency: call at a floor other than the current one -> first step pulse 2 cycles later (latch + IDLE decide). Call at current floor in IDLE -> door_open 2 cycles later.
- hold is high only in DOOR, so step pulses never coincide with hold.
- Reset mid-operation: all state cleared immediately (async). No pulse is emitted in the reset-release cycle.

Optional Feature:
Macro CALL_SCHED_ESTOP_EN adds input estop_n (1 bit, active-low) and state HALT.
- Defined:
  - estop_n=0 forces HALT from any state next cycle: hold=1, up_n=down_n=1, door_open=0, pending retained, new calls still latched.
  - estop_n=1 returns HALT -> IDLE.
  - An in-flight STEP pulse is suppressed.
- Undefined: no port, no HALT state; behaviour as above.

Decomposition:
- Package elevador_pkg: state enum (IDLE, STEP, SETTLE, DOOR, HALT), FLOORS/FLOOR_W defaults, DOOR_CYCLES/SETTLE_CYCLES defaults.
- Sub-module call_register: pending flops, set/clear, ahead_up/ahead_dn/here reductions.
- FSM and timers stay in elevator_call_scheduler.
- Bench closes the loop with the existing up/down counter (cur_floor = counter count).

Test Plan:
1. Reset, cur_floor=0, pulse call_n[3]=0 for 1 cycle -> exactly 3 up_n pulses, each separated by SETTLE_CYCLES; at floor 3, door_open=1 and hold=1 for 4 cycles; pending[3]=0; then IDLE.
2. At floor 0, calls 5 and 2 together -> stop at 2 (door), then continue up to 5 (door), with dir_up=1 throughout.
3. At floor 5 travelling up, call 7 and call 1 pending -> serve 7 first, then reverse (dir_up=0) and serve 1. No up pulse at floor 7.
4. Door open at 4 with 2 cycles left, call_n[4]=0 -> timer restarts; door_open stays high 4 more cycles.
5. Assert reset during SETTLE mid-travel -> all outputs at reset values the same cycle; pending=0; no pulses after release until a new call.
6. (CALL_SCHED_ESTOP_EN) estop_n=0 during travel -> hold=1, no pulses, pending kept. Release -> travel resumes to the original target.
